// File: rtl/relogio_pkg.sv
// Shared types and helpers for the time-setting controller.
package relogio_pkg;

    typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} estado_t;

    typedef struct packed {
        logic [3:0] h_msd;
        logic [3:0] h_lsd;
        logic [3:0] m_msd;
        logic [3:0] m_lsd;
        logic [3:0] s_msd;
        logic [3:0] s_lsd;
    } bcd_time_t;

    localparam int unsigned MAX_H = 23;
    localparam int unsigned MAX_M = 59;

    // Two-digit BCD increment; wraps to 00 at max_val, and any invalid input also becomes 00.
    function automatic logic [7:0] bcd_inc2(input logic [3:0] msd, input logic [3:0] lsd,
                                            input int unsigned max_val);
        logic [7:0]  r;
        int unsigned val;
        val = 32'(msd) * 10 + 32'(lsd);
        if (msd > 4'd9 || lsd > 4'd9 || val >= max_val) begin
            r = 8'h00;
        end else if (lsd == 4'd9) begin
            r = {msd + 4'd1, 4'd0};
        end else begin
            r = {msd, lsd + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/botao_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and press-event pulse.
module botao_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [1:0]      vld_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            suppress_q, suppress_d;
    logic            press_q, press_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 2'b11;
            vld_q      <= 2'b00;
            cnt_q      <= '0;
            level_q    <= 1'b1;
            suppress_q <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_ni};
            vld_q      <= {vld_q[0], 1'b1};
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            suppress_q <= suppress_d;
            press_q    <= press_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d   = '0;
            level_d = sync_q[1];
            press_d = ~sync_q[1] & ~suppress_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Events stay muted until the button has been seen released once after reset.
        suppress_d = suppress_q & ~(vld_q[1] & sync_q[1] & level_q);
    end

    assign press_o = press_q;

endmodule

// File: rtl/relogio_ajuste.sv
// Time-setting controller: RUN/SET_H/SET_M/SET_S editing of a shadow time with field blink.
module relogio_ajuste import relogio_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_CYCLES    = 12_500_000
) (
    input  logic        CLOCK_50,
    input  logic        KEY,
    input  logic        btn_mode_n,
    input  logic        btn_inc_n,
    input  logic [23:0] cur_time,
    output logic [23:0] set_time,
    output logic        load,
    output logic        running,
    output logic [5:0]  blank_mask
);

    localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_CYCLES - 1);

    logic              mode_ev, inc_ev;
    estado_t           state_q, state_d;
    bcd_time_t         shadow_q, shadow_d;
    logic              load_q, load_d;
    logic              running_q, running_d;
    logic [5:0]        blank_q, blank_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_ph_q, blink_ph_d;

    botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
        .clk_i   (CLOCK_50),
        .rst_ni  (KEY),
        .btn_ni  (btn_mode_n),
        .press_o (mode_ev)
    );

    botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
        .clk_i   (CLOCK_50),
        .rst_ni  (KEY),
        .btn_ni  (btn_inc_n),
        .press_o (inc_ev)
    );

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q     <= RUN;
            shadow_q    <= '0;
            load_q      <= 1'b0;
            running_q   <= 1'b1;
            blank_q     <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            load_q      <= load_d;
            running_q   <= running_d;
            blank_q     <= blank_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    // Mode always takes priority over a simultaneous inc.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        load_d   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mode_ev) begin
                    shadow_d = bcd_time_t'(cur_time);
                    state_d  = SET_H;
                end
            end
            SET_H: begin
                if (mode_ev) begin
                    state_d = SET_M;
                end else if (inc_ev) begin
                    {shadow_d.h_msd, shadow_d.h_lsd} =
                        bcd_inc2(shadow_q.h_msd, shadow_q.h_lsd, MAX_H);
                end
            end
            SET_M: begin
                if (mode_ev) begin
                    state_d = SET_S;
                end else if (inc_ev) begin
                    {shadow_d.m_msd, shadow_d.m_lsd} =
                        bcd_inc2(shadow_q.m_msd, shadow_q.m_lsd, MAX_M);
                end
            end
            SET_S: begin
                if (mode_ev) begin
                    state_d = RUN;
                    load_d  = 1'b1;
                end else if (inc_ev) begin
                    shadow_d.s_msd = 4'd0;
                    shadow_d.s_lsd = 4'd0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        if (state_d != state_q || inc_ev) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == BlinkMax) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end

        running_d = (state_d == RUN);
        blank_d   = '0;
        if (blink_ph_d) begin
            unique case (state_d)
                SET_H:   blank_d = 6'b110000;
                SET_M:   blank_d = 6'b001100;
                SET_S:   blank_d = 6'b000011;
                default: blank_d = 6'b000000;
            endcase
        end
    end

    assign set_time   = shadow_q;
    assign load       = load_q;
    assign running    = running_q;
    assign blank_mask = blank_q;

endmodule

// File: doc/relogio_ajuste.md
# relogio_ajuste

Time-setting controller placed directly upstream of the clock counter core. It debounces two raw pushbuttons and walks a RUN → SET_H → SET_M → SET_S state machine. The time being edited is held in a shadow register seeded from the running time, and is loaded back into the counter core on exit. It also produces a per-digit blank mask so the field under edit blinks on the six-digit display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: cycles a synchronized button level must stay stable before it is accepted (20 ms at 50 MHz).
- BLINK_CYCLES, default 12_500_000: half-period of the edit-field blink (0.25 s at 50 MHz).

Ports:
- CLOCK_50  in  1: single system clock; all logic is on the rising edge.
- KEY  in  1: reset, asynchronous, active-low.
- btn_mode_n  in  1: raw mode pushbutton, active-low, asynchronous to CLOCK_50.
- btn_inc_n  in  1: raw increment pushbutton, active-low, asynchronous to CLOCK_50.
- cur_time  in  24: running time from the counter core, BCD hh:mm:ss, packed [23:20]=h_msd … [3:0]=s_lsd.
- set_time  out  24: shadow time, same packing.
- load  out  1: single-cycle pulse; the counter core copies set_time on this cycle.
- running  out  1: high when the counter core may count; low in all SET states.
- blank_mask  out  6: bit i high blanks display digit i (bit 0 = s_lsd … bit 5 = h_msd).

## Operation
- Each button has a 2-FF synchronizer, then a stability counter. A press event is a single-cycle pulse issued when the accepted level changes from released to pressed. Releases produce no event. Holding a button never repeats the event.
- RUN:
  - running=1.
  - A mode event copies cur_time into the shadow register and moves to SET_H.
  - Inc events are ignored.
- SET_H:
  - An inc event adds 1 to the hours: 23→00; 09→10; 19→20.
  - If the captured hour is invalid (above 23 or non-BCD), the next inc sets it to 00.
  - A mode event moves to SET_M.
- SET_M:
  - An inc event adds 1 to the minutes: 59→00, with no carry into the hours.
  - A non-BCD or out-of-range minute value becomes 00 on the next inc.
  - A mode event moves to SET_S.
- SET_S:
  - An inc event clears the seconds to 00.
  - A mode event asserts load for one cycle with the current shadow value, then moves to RUN.
- Mode and inc events in the same cycle: mode wins and the inc is dropped.
- Blink:
  - In a SET state, the two digits of the selected field are blanked during odd half-periods of the blink counter. All other digits are always visible. In RUN, blank_mask=000000.
  - The blink counter restarts on every state change and on every inc event, so the field is visible for the first BLINK_CYCLES afterwards.
- Reset (KEY=0), at any time including mid-edit:
  - State RUN, shadow 000000, set_time=000000, load=0, running=1, blank_mask=000000.
  - Synchronizers at the released level, debounce and blink counters at 0.
  - A press held through reset release produces no event.

## Timing
- Raw button to accepted level: 2 synchronizer cycles + DEBOUNCE_CYCLES.
- The event pulse occurs on the cycle the accepted level changes. State and shadow update on the next edge.
- Leaving RUN: cur_time is sampled on the event cycle, so set_time shows it one cycle after the event. running drops on that same edge.
- Leaving SET_S: load=1 for exactly one cycle. running rises on the same edge as load and stays high.
- set_time is valid and stable whenever load=1.
- Outputs are registered; nothing combinational passes from input to output.

## Structure
- Package relogio_pkg:
  - state enum: RUN, SET_H, SET_M, SET_S.
  - bcd_time_t: a packed struct of six 4-bit digits matching the 24-bit packing above.
  - constants: MAX_H=23, MAX_M=59.
  - a function for BCD two-digit increment with wrap limit.
- One sub-module, botao_debounce (synchronizer, stability counter, press-event pulse), instantiated twice with DEBOUNCE_CYCLES passed through.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and BLINK_CYCLES=8.
1. Reset mid-edit: enter SET_M, assert KEY=0 → state RUN, set_time=000000, running=1, blank_mask=0, load=0.
2. Glitch rejection: mode low for 3 cycles, then released → no state change. Mode low for 10 cycles → exactly one transition to SET_H.
3. cur_time=235958, then mode, inc → hour 00, set_time=005958. Then mode, inc ×2 → set_time=000158 (no carry into the hours).
4. In SET_S, inc → set_time=000100. Then mode → load high exactly one cycle with set_time=000100, running=1 from that edge.
5. Mode and inc events in the same cycle while in SET_H → state SET_M, hour unchanged.
6. Blink in SET_H → blank_mask alternates 000000 / 110000 every 8 cycles. An inc event restarts the counter: 000000 for the next 8 cycles.
